// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I types and constants
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  // Encoding is {funct7[5], funct3} so the decoder can pass fields straight through.
  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SLL   = 4'b0001,
    ALU_SLT   = 4'b0010,
    ALU_SLTU  = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_OR    = 4'b0110,
    ALU_AND   = 4'b0111,
    ALU_SUB   = 4'b1000,
    ALU_PASSB = 4'b1001,
    ALU_SRA   = 4'b1101
  } alu_op_t;

endpackage

// File: rtl/rv32i_alu_if.sv
// rtl/rv32i_alu_if.sv - execute-stage ALU operand/result bundle
interface rv32i_alu_if;
  import rv32i_pkg::*;

  alu_op_t             alu_op;
  logic [XLEN-1:0]     alu_in1;
  logic [XLEN-1:0]     alu_in2;
  logic [XLEN-1:0]     alu_out;
  logic                alu_zero;
  logic                cmp_eq;
  logic                cmp_lt;
  logic                cmp_ltu;

  modport master (
    output alu_op, alu_in1, alu_in2,
    input  alu_out, alu_zero, cmp_eq, cmp_lt, cmp_ltu
  );

  modport slave (
    input  alu_op, alu_in1, alu_in2,
    output alu_out, alu_zero, cmp_eq, cmp_lt, cmp_ltu
  );

endinterface

// File: rtl/rv32i_alu_core.sv
// rtl/rv32i_alu_core.sv - combinational RV32I result and compare logic
module rv32i_alu_core
  import rv32i_pkg::*;
(
  input  alu_op_t         op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o,
  output logic            eq_o,
  output logic            lt_o,
  output logic            ltu_o
);

  logic [4:0] shamt;
  logic       lt_s;
  logic       lt_u;

  assign shamt = b_i[4:0];
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;

  assign eq_o  = (a_i == b_i);
  assign lt_o  = lt_s;
  assign ltu_o = lt_u;

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:   result_o = a_i + b_i;
      ALU_SUB:   result_o = a_i - b_i;
      ALU_SLL:   result_o = a_i << shamt;
      ALU_SLT:   result_o = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU:  result_o = {{(XLEN-1){1'b0}}, lt_u};
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_SRL:   result_o = a_i >> shamt;
      ALU_SRA:   result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_OR:    result_o = a_i | b_i;
      ALU_AND:   result_o = a_i & b_i;
      ALU_PASSB: result_o = b_i;
      default:   result_o = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_alu.sv
// rtl/rv32i_alu.sv - registered execute-stage ALU, one-cycle latency
module rv32i_alu
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  rv32i_alu_if.slave  alu
);

  logic [XLEN-1:0] out_d, out_q;
  logic            zero_d, zero_q;
  logic            eq_d, eq_q;
  logic            lt_d, lt_q;
  logic            ltu_d, ltu_q;

  rv32i_alu_core u_core (
    .op_i     (alu.alu_op),
    .a_i      (alu.alu_in1),
    .b_i      (alu.alu_in2),
    .result_o (out_d),
    .eq_o     (eq_d),
    .lt_o     (lt_d),
    .ltu_o    (ltu_d)
  );

  // Zero flag comes from the same next-state value so it never lags alu_out.
  assign zero_d = (out_d == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q  <= '0;
      zero_q <= 1'b0;
      eq_q   <= 1'b0;
      lt_q   <= 1'b0;
      ltu_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      zero_q <= zero_d;
      eq_q   <= eq_d;
      lt_q   <= lt_d;
      ltu_q  <= ltu_d;
    end
  end

  assign alu.alu_out  = out_q;
  assign alu.alu_zero = zero_q;
  assign alu.cmp_eq   = eq_q;
  assign alu.cmp_lt   = lt_q;
  assign alu.cmp_ltu  = ltu_q;

endmodule

// File: tb/tb_rv32i_alu.sv
// tb/tb_rv32i_alu.sv - directed self-checking bench for rv32i_alu
module tb_rv32i_alu;
  import rv32i_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  rv32i_alu_if alu_bus ();

  rv32i_alu dut (
    .clk   (clk),
    .reset (reset),
    .alu   (alu_bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic z, input logic eq,
                             input logic lt, input logic ltu);
    check({tag, ".zero"}, {31'b0, alu_bus.alu_zero}, {31'b0, z});
    check({tag, ".eq"},   {31'b0, alu_bus.cmp_eq},   {31'b0, eq});
    check({tag, ".lt"},   {31'b0, alu_bus.cmp_lt},   {31'b0, lt});
    check({tag, ".ltu"},  {31'b0, alu_bus.cmp_ltu},  {31'b0, ltu});
  endtask

  // Drive operands away from the edge, then sample 1 time unit after the capturing edge.
  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_bus.alu_op  = alu_op_t'(op);
    alu_bus.alu_in1 = a;
    alu_bus.alu_in2 = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [4:0]  sh;
    logic        slt;
    sh  = b[4:0];
    slt = (a[31] != b[31]) ? a[31] : (a < b);
    case (op)
      4'h0: return a + b;
      4'h8: return a + ~b + 32'd1;
      4'h1: return a << sh;
      4'h2: return {31'b0, slt};
      4'h3: return {31'b0, a < b};
      4'h4: return a ^ b;
      4'h5: return a >> sh;
      4'hD: return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      4'h6: return a | b;
      4'h7: return a & b;
      4'h9: return b;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_model(input string tag, input logic [3:0] op,
                             input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = model(op, a, b);
    check({tag, ".out"}, alu_bus.alu_out, r);
    check_flags(tag, r == 32'h0, a == b, (a[31] != b[31]) ? a[31] : (a < b), a < b);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;

    // Held in reset: operands present but outputs must stay clear.
    alu_bus.alu_op  = ALU_ADD;
    alu_bus.alu_in1 = 32'd5;
    alu_bus.alu_in2 = 32'd3;
    repeat (2) @(posedge clk);
    #1;
    check("rst.out", alu_bus.alu_out, 32'h0);
    check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rel.out", alu_bus.alu_out, 32'd8);

    step(4'h0, 32'hFFFF_FFFF, 32'h1);
    check("add_wrap.out", alu_bus.alu_out, 32'h0);
    check_flags("add_wrap", 1'b1, 1'b0, 1'b1, 1'b0);
    step(4'h8, 32'h0, 32'h1);
    check("sub_wrap.out", alu_bus.alu_out, 32'hFFFF_FFFF);
    check("sub_wrap.zero", {31'b0, alu_bus.alu_zero}, 32'h0);

    step(4'h1, 32'h8000_0000, 32'h24);
    check("sll.out", alu_bus.alu_out, 32'h0);
    step(4'h5, 32'h8000_0000, 32'h24);
    check("srl.out", alu_bus.alu_out, 32'h0800_0000);
    step(4'hD, 32'h8000_0000, 32'h24);
    check("sra.out", alu_bus.alu_out, 32'hF800_0000);

    step(4'h2, 32'hFFFF_FFFF, 32'h1);
    check("slt.out", alu_bus.alu_out, 32'h1);
    check_flags("slt", 1'b0, 1'b0, 1'b1, 1'b0);
    step(4'h3, 32'hFFFF_FFFF, 32'h1);
    check("sltu.out", alu_bus.alu_out, 32'h0);
    check_flags("sltu", 1'b1, 1'b0, 1'b1, 1'b0);
    step(4'h0, 32'd7, 32'd7);
    check("eq.out", alu_bus.alu_out, 32'd14);
    check_flags("eq", 1'b0, 1'b1, 1'b0, 1'b0);

    step(4'h7, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check("and.out", alu_bus.alu_out, 32'h00F0_00F0);
    step(4'h6, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check("or.out", alu_bus.alu_out, 32'hFFF0_FFF0);
    step(4'h4, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check("xor.out", alu_bus.alu_out, 32'hFF00_FF00);
    step(4'h9, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check("passb.out", alu_bus.alu_out, 32'h0FF0_0FF0);
    step(4'hF, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check("illegal.out", alu_bus.alu_out, 32'h0);
    check("illegal.zero", {31'b0, alu_bus.alu_zero}, 32'h1);

    for (int i = 0; i < 10; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = (i % 3 == 0) ? a : $urandom;
      step(op, a, b);
      check_model($sformatf("b2b%0d", i), op, a, b);
    end

    // Asynchronous reset pulse mid-stream must clear outputs without waiting for clk.
    reset = 1'b0;
    #1;
    check("mid_rst.out", alu_bus.alu_out, 32'h0);
    check_flags("mid_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("mid_rst_hold.out", alu_bus.alu_out, 32'h0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      step(op, a, b);
      check_model($sformatf("resume%0d", i), op, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
